// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port, with a pending-write scoreboard.
// Define WB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module regfile_wb_arbiter #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned REG_COUNT = 8,
  parameter int unsigned IDX_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s0_valid,
  output logic                 s0_ready,
  input  logic [IDX_W-1:0]     s0_rd,
  input  logic [XLEN-1:0]      s0_data,
  input  logic                 s1_valid,
  output logic                 s1_ready,
  input  logic [IDX_W-1:0]     s1_rd,
  input  logic [XLEN-1:0]      s1_data,
  output logic                 rf_we,
  output logic [IDX_W-1:0]     rf_rd,
  output logic [XLEN-1:0]      rf_data,
  input  logic                 mark_valid,
  input  logic [IDX_W-1:0]     mark_idx,
  output logic [REG_COUNT-1:0] busy
);

  logic                 grant0;
  logic                 grant1;
  logic                 xfer;
  logic [IDX_W-1:0]     xfer_rd;
  logic [XLEN-1:0]      xfer_data;
  logic [REG_COUNT-1:0] busy_d;

`ifdef WB_RR_EN
  typedef enum logic {
    LAST_P0 = 1'b0,
    LAST_P1 = 1'b1
  } last_e;

  last_e last_q;
  last_e last_d;

  // Last-granted port; reset value lets port 0 win the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= LAST_P1;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    last_d = last_q;
    if (!rst) begin
      if (s0_valid && s1_valid) begin
        grant0 = (last_q == LAST_P1);
        grant1 = (last_q == LAST_P0);
      end else begin
        grant0 = s0_valid;
        grant1 = s1_valid;
      end
    end
    if (grant0) begin
      last_d = LAST_P0;
    end else if (grant1) begin
      last_d = LAST_P1;
    end
  end
`else
  // Fixed priority: port 0 always wins contention.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      grant0 = s0_valid;
      grant1 = s1_valid && !s0_valid;
    end
  end
`endif

  assign s0_ready  = grant0;
  assign s1_ready  = grant1;
  assign xfer      = grant0 || grant1;
  assign xfer_rd   = grant1 ? s1_rd : s0_rd;
  assign xfer_data = grant1 ? s1_data : s0_data;

  // Scoreboard next state; a mark on the same edge as the commit wins.
  always_comb begin
    busy_d = busy;
    for (int unsigned i = 1; i < REG_COUNT; i++) begin
      if (rf_we && (rf_rd == IDX_W'(i))) begin
        busy_d[i] = 1'b0;
      end
      if (mark_valid && (mark_idx == IDX_W'(i))) begin
        busy_d[i] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  // Output register stage; index-0 writes are consumed without a write enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we   <= 1'b0;
      rf_rd   <= '0;
      rf_data <= '0;
      busy    <= '0;
    end else begin
      rf_we <= xfer && (xfer_rd != '0);
      if (xfer) begin
        rf_rd   <= xfer_rd;
        rf_data <= xfer_data;
      end
      busy <= busy_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (follows WB_RR_EN if defined).
module tb_regfile_wb_arbiter;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_COUNT = 8;
  localparam int unsigned IDX_W     = 3;
`ifdef WB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 s0_valid, s1_valid;
  logic                 s0_ready, s1_ready;
  logic [IDX_W-1:0]     s0_rd, s1_rd;
  logic [XLEN-1:0]      s0_data, s1_data;
  logic                 rf_we;
  logic [IDX_W-1:0]     rf_rd;
  logic [XLEN-1:0]      rf_data;
  logic                 mark_valid;
  logic [IDX_W-1:0]     mark_idx;
  logic [REG_COUNT-1:0] busy;

  int total = 0;
  int bad   = 0;

  regfile_wb_arbiter #(.XLEN(XLEN), .REG_COUNT(REG_COUNT), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_rd(s0_rd), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_rd(s1_rd), .s1_data(s1_data),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data),
    .mark_valid(mark_valid), .mark_idx(mark_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s0_valid = 1'b0; s1_valid = 1'b0; mark_valid = 1'b0;
    s0_rd = '0; s1_rd = '0; mark_idx = '0;
    s0_data = '0; s1_data = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    s0_valid = 1'b1; s0_rd = 3'd1;
    s1_valid = 1'b1; s1_rd = 3'd2;
    #1;
    total++; if (s0_ready !== 1'b0) begin bad++; $display("FAIL reset_s0_ready got=%0h exp=0", s0_ready); end
    total++; if (s1_ready !== 1'b0) begin bad++; $display("FAIL reset_s1_ready got=%0h exp=0", s1_ready); end
    tick();
    tick();
    rst = 1'b0;
    idle();
    #1;
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we got=%0h exp=0", rf_we); end
    total++; if (busy !== 8'h00) begin bad++; $display("FAIL reset_busy got=%0h exp=00", busy); end
    total++; if (rf_data !== 32'h0) begin bad++; $display("FAIL reset_rf_data got=%0h exp=0", rf_data); end
  endtask

  task automatic test_single();
    s0_valid = 1'b1; s0_rd = 3'd3; s0_data = 32'hDEADBEEF;
    #1;
    total++; if (s0_ready !== 1'b1) begin bad++; $display("FAIL single_s0_ready got=%0h exp=1", s0_ready); end
    total++; if (s1_ready !== 1'b0) begin bad++; $display("FAIL single_s1_ready got=%0h exp=0", s1_ready); end
    tick();
    idle();
    total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL single_rf_we got=%0h exp=1", rf_we); end
    total++; if (rf_rd !== 3'd3) begin bad++; $display("FAIL single_rf_rd got=%0h exp=3", rf_rd); end
    total++; if (rf_data !== 32'hDEADBEEF) begin bad++; $display("FAIL single_rf_data got=%0h exp=deadbeef", rf_data); end
    tick();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL single_idle_rf_we got=%0h exp=0", rf_we); end
    total++; if (rf_data !== 32'hDEADBEEF) begin bad++; $display("FAIL single_hold_rf_data got=%0h exp=deadbeef", rf_data); end
  endtask

  task automatic test_contention();
    bit exp_g0;
    do_reset();
    s0_valid = 1'b1; s0_rd = 3'd1; s0_data = 32'h1111_1111;
    s1_valid = 1'b1; s1_rd = 3'd2; s1_data = 32'h2222_2222;
    for (int k = 0; k < 4; k++) begin
      exp_g0 = RR ? (k % 2 == 0) : 1'b1;
      #1;
      total++; if (s0_ready !== exp_g0) begin bad++; $display("FAIL cont%0d_s0_ready got=%0h exp=%0h", k, s0_ready, exp_g0); end
      total++; if (s1_ready !== !exp_g0) begin bad++; $display("FAIL cont%0d_s1_ready got=%0h exp=%0h", k, s1_ready, !exp_g0); end
      tick();
      total++; if (rf_rd !== (exp_g0 ? 3'd1 : 3'd2)) begin bad++; $display("FAIL cont%0d_rf_rd got=%0h exp=%0h", k, rf_rd, exp_g0 ? 1 : 2); end
      total++; if (rf_data !== (exp_g0 ? 32'h1111_1111 : 32'h2222_2222)) begin bad++; $display("FAIL cont%0d_rf_data got=%0h", k, rf_data); end
    end
    s0_valid = 1'b0;
    #1;
    total++; if (s1_ready !== 1'b1) begin bad++; $display("FAIL cont_lone_s1_ready got=%0h exp=1", s1_ready); end
    tick();
    idle();
    total++; if (rf_rd !== 3'd2 || rf_we !== 1'b1) begin bad++; $display("FAIL cont_lone_rf got=%0h/%0h exp=2/1", rf_rd, rf_we); end
  endtask

  task automatic test_x0();
    do_reset();
    mark_valid = 1'b1; mark_idx = 3'd6;
    tick();
    idle();
    s1_valid = 1'b1; s1_rd = 3'd0; s1_data = 32'h55;
    #1;
    total++; if (s1_ready !== 1'b1) begin bad++; $display("FAIL x0_s1_ready got=%0h exp=1", s1_ready); end
    tick();
    idle();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL x0_rf_we got=%0h exp=0", rf_we); end
    total++; if (busy !== 8'h40) begin bad++; $display("FAIL x0_busy got=%0h exp=40", busy); end
    tick();
    total++; if (busy !== 8'h40) begin bad++; $display("FAIL x0_busy_after got=%0h exp=40", busy); end
  endtask

  task automatic test_scoreboard();
    do_reset();
    mark_valid = 1'b1; mark_idx = 3'd5;
    tick();
    idle();
    total++; if (busy !== 8'h20) begin bad++; $display("FAIL sb_mark_busy got=%0h exp=20", busy); end
    mark_valid = 1'b1; mark_idx = 3'd0;
    tick();
    idle();
    total++; if (busy !== 8'h20) begin bad++; $display("FAIL sb_mark0_busy got=%0h exp=20", busy); end
    s0_valid = 1'b1; s0_rd = 3'd5; s0_data = 32'hA5A5_0005;
    tick();
    idle();
    total++; if (rf_we !== 1'b1 || busy !== 8'h20) begin bad++; $display("FAIL sb_inflight got we=%0h busy=%0h exp 1/20", rf_we, busy); end
    tick();
    total++; if (busy !== 8'h00) begin bad++; $display("FAIL sb_clear_busy got=%0h exp=00", busy); end
    // Mark lands on the same edge as the commit of register 5.
    mark_valid = 1'b1; mark_idx = 3'd5;
    tick();
    idle();
    s0_valid = 1'b1; s0_rd = 3'd5; s0_data = 32'h0BAD_0005;
    tick();
    idle();
    mark_valid = 1'b1; mark_idx = 3'd5;
    total++; if (rf_we !== 1'b1 || rf_rd !== 3'd5) begin bad++; $display("FAIL sb_same_rf got we=%0h rd=%0h exp 1/5", rf_we, rf_rd); end
    tick();
    idle();
    total++; if (busy !== 8'h20) begin bad++; $display("FAIL sb_same_edge_busy got=%0h exp=20", busy); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 1; k < 4; k++) begin
      s0_valid = 1'b1; s0_rd = IDX_W'(k); s0_data = 32'hC000_0000 + 32'(k);
      tick();
      total++; if (rf_we !== 1'b1 || rf_rd !== IDX_W'(k) || rf_data !== 32'hC000_0000 + 32'(k)) begin
        bad++; $display("FAIL b2b%0d got we=%0h rd=%0h data=%0h", k, rf_we, rf_rd, rf_data);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    mark_valid = 1'b1; mark_idx = 3'd4;
    tick();
    idle();
    s0_valid = 1'b1; s0_rd = 3'd4; s0_data = 32'h4444_4444;
    tick();
    rst = 1'b1;
    #1;
    total++; if (s0_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_s0_ready got=%0h exp=0", s0_ready); end
    tick();
    rst = 1'b0;
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL mid_rf_we got=%0h exp=0", rf_we); end
    total++; if (busy !== 8'h00) begin bad++; $display("FAIL mid_busy got=%0h exp=00", busy); end
    #1;
    total++; if (s0_ready !== 1'b1) begin bad++; $display("FAIL mid_rearb_s0_ready got=%0h exp=1", s0_ready); end
    tick();
    idle();
    total++; if (rf_we !== 1'b1 || rf_rd !== 3'd4) begin bad++; $display("FAIL mid_rearb_rf got we=%0h rd=%0h exp 1/4", rf_we, rf_rd); end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_x0();
    test_scoreboard();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
